// File: rtl/swan_pkg.sv
// Shared SWAN128 constants: half-block geometry, the 4-bit S-box and the
// state encoding used by the serial S-box layer.
package swan_pkg;

    localparam int unsigned BLOCK_SIZE  = 128;
    localparam int unsigned SIDE_SIZE   = BLOCK_SIZE / 2;
    localparam int unsigned COLUMN_SIZE = SIDE_SIZE / 4;

    // Entry i sits at packed index i, so entry 0 is the rightmost nibble.
    localparam logic [15:0][3:0] SBOX4 = {
        4'hE, 4'h8, 4'h0, 4'h5, 4'h7, 4'hB, 4'hD, 4'h2,
        4'h9, 4'h3, 4'hF, 4'h6, 4'hC, 4'h4, 4'hA, 4'h1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sbox_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX4[x];
    endfunction

endpackage

// File: rtl/serial_sbox_slice.sv
// Combinational S-box bank: substitutes SBOX_PER_CYCLE bitsliced columns.
// Row 0 carries the nibble MSB, row 3 the LSB.
module serial_sbox_slice
    import swan_pkg::*;
#(
    parameter int unsigned SBOX_PER_CYCLE = 4
) (
    input  logic [3:0][0:SBOX_PER_CYCLE-1] rows_i,
    output logic [3:0][0:SBOX_PER_CYCLE-1] rows_o
);

    for (genvar c = 0; c < SBOX_PER_CYCLE; c++) begin : g_col
        logic [3:0] nib_in;
        logic [3:0] nib_out;

        assign nib_in       = {rows_i[0][c], rows_i[1][c], rows_i[2][c], rows_i[3][c]};
        assign nib_out      = sbox4(nib_in);
        assign rows_o[0][c] = nib_out[3];
        assign rows_o[1][c] = nib_out[2];
        assign rows_o[2][c] = nib_out[1];
        assign rows_o[3][c] = nib_out[0];
    end

endmodule

// File: rtl/serial_sbox_layer.sv
// Serial SWAN128 nonlinear stage: substitutes a 64-bit half-block one column
// group per clock and hands the result downstream over valid/ready.
module serial_sbox_layer
    import swan_pkg::*;
#(
    parameter int unsigned SBOX_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:SIDE_SIZE-1] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:SIDE_SIZE-1] out_data
);

    localparam int unsigned GROUPS = COLUMN_SIZE / SBOX_PER_CYCLE;
    localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned IDX_W  = $clog2(SIDE_SIZE);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    if ((COLUMN_SIZE % SBOX_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("serial_sbox_layer: SBOX_PER_CYCLE must divide COLUMN_SIZE");
    end

    sbox_state_e                         state_q, state_d;
    logic [0:SIDE_SIZE-1]                st_q, st_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                in_ready_q, out_valid_q;
    logic [3:0][0:SBOX_PER_CYCLE-1]      grp_in, grp_out;

    // Pick the four row slices of the current column group.
    always_comb begin
        grp_in = '0;
        for (int r = 0; r < 4; r++) begin
            grp_in[r] = st_q[IDX_W'(r * COLUMN_SIZE + 32'(cnt_q) * SBOX_PER_CYCLE) +: SBOX_PER_CYCLE];
        end
    end

    serial_sbox_slice #(
        .SBOX_PER_CYCLE(SBOX_PER_CYCLE)
    ) u_slice (
        .rows_i(grp_in),
        .rows_o(grp_out)
    );

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int r = 0; r < 4; r++) begin
                    st_d[IDX_W'(r * COLUMN_SIZE + 32'(cnt_q) * SBOX_PER_CYCLE) +: SBOX_PER_CYCLE] = grp_out[r];
                end
                if (cnt_q == LAST_GRP) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = st_q;

endmodule

// File: tb/tb_serial_sbox_layer.sv
// Bench for serial_sbox_layer: three instances (4, 1 and 16 columns per clock)
// checked against a per-column S-box model of the half-block.
module tb_serial_sbox_layer;

    logic             clk;
    logic             rst;
    logic [2:0]       in_valid;
    logic [2:0]       in_ready;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [2:0][0:63] in_data;
    logic [2:0][0:63] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int sb_tbl[16] = '{1, 10, 4, 12, 6, 15, 3, 9, 2, 13, 11, 7, 5, 0, 8, 14};

    typedef struct {
        logic [0:63] din;
        logic [0:63] dout;
    } vec_t;

    vec_t vecs[4];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned SPC = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        serial_sbox_layer #(
            .SBOX_PER_CYCLE(SPC)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int groups_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
    endfunction

    // Reference: gather each column nibble (row 0 = MSB), look it up, scatter back.
    function automatic logic [0:63] ref_sub(input logic [0:63] x);
        logic [0:63] y;
        int          nib;
        int          s;
        y = '0;
        for (int j = 0; j < 16; j++) begin
            nib = 0;
            for (int r = 0; r < 4; r++) nib = nib * 2 + (x[r * 16 + j] ? 1 : 0);
            s = sb_tbl[nib];
            for (int r = 0; r < 4; r++) y[r * 16 + j] = ((s >> (3 - r)) & 1) == 1;
        end
        return y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, expect it after GROUPS edges, then a one-cycle handshake.
    task automatic run_block(input int d, input logic [0:63] data, input logic [0:63] exp, input string name);
        int lat;
        int w;
        in_data[d]   = data;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b1;
        w = 0;
        while (!in_ready[d] && w < 40) begin
            tick();
            w++;
        end
        check({name, " ready_before_accept"}, 64'(in_ready[d]), 64'd1);
        tick();
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            tick();
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(groups_of(d)));
        check({name, " data"}, out_data[d], exp);
        check({name, " ready_in_done"}, 64'(in_ready[d]), 64'd0);
        tick();
        check({name, " valid_after_hs"}, 64'(out_valid[d]), 64'd0);
        check({name, " ready_after_hs"}, 64'(in_ready[d]), 64'd1);
    endtask

    // Eight blocks with both sides always willing; results every GROUPS+2 cycles, in order.
    task automatic run_stream(input int d);
        logic [0:63] blk[8];
        int          ni;
        int          no;
        int          prev;
        bit          acc;
        int          budget;
        ni   = 0;
        no   = 0;
        prev = -1;
        budget = 8 * (groups_of(d) + 2) + 30;
        for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom};
        out_ready[d] = 1'b1;
        for (int cyc = 0; cyc < budget && no < 8; cyc++) begin
            in_valid[d] = (ni < 8);
            if (ni < 8) in_data[d] = blk[ni];
            acc = in_ready[d] && (ni < 8);
            if (out_valid[d]) begin
                check($sformatf("stream%0d data%0d", d, no), out_data[d], ref_sub(blk[no]));
                if (no > 0) check($sformatf("stream%0d gap%0d", d, no), 64'(cyc - prev), 64'(groups_of(d) + 2));
                prev = cyc;
                no++;
            end
            tick();
            if (acc) ni++;
        end
        in_valid[d] = 1'b0;
        n_checks++;
        if (no < 8) begin
            n_fail++;
            $display("FAIL stream%0d timeout: got %0d results expected 8", d, no);
        end
    endtask

    initial begin
        logic [0:63] hold;
        logic [0:63] r;
        vecs[0] = '{din: 64'h0000_0000_0000_0000, dout: 64'h0000_0000_0000_FFFF};
        vecs[1] = '{din: 64'hFFFF_FFFF_FFFF_FFFF, dout: 64'hFFFF_FFFF_FFFF_0000};
        vecs[2] = '{din: 64'h8000_0000_0000_0000, dout: 64'h0000_0000_8000_7FFF};
        vecs[3] = '{din: 64'h0000_0000_0000_FFFF, dout: 64'hFFFF_0000_FFFF_0000};

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset%0d in_ready", d), 64'(in_ready[d]), 64'd1);
            check($sformatf("reset%0d out_valid", d), 64'(out_valid[d]), 64'd0);
            check($sformatf("reset%0d out_data", d), out_data[d], 64'd0);
        end

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                run_block(d, vecs[i].din, vecs[i].dout, $sformatf("vec%0d dut%0d", i, d));
            end
            for (int i = 0; i < 3; i++) begin
                r = {$urandom, $urandom};
                run_block(d, r, ref_sub(r), $sformatf("rnd%0d dut%0d", i, d));
            end
        end

        // Downstream stall with a competing input offer while DONE.
        r = {$urandom, $urandom};
        hold = ref_sub(r);
        out_ready[0] = 1'b0;
        in_data[0]   = r;
        in_valid[0]  = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int w = 0; w < 40 && !out_valid[0]; w++) tick();
        in_valid[0] = 1'b1;
        in_data[0]  = ~r;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall%0d valid", i), 64'(out_valid[0]), 64'd1);
            check($sformatf("stall%0d data", i), out_data[0], hold);
            check($sformatf("stall%0d ready", i), 64'(in_ready[0]), 64'd0);
            tick();
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        check("stall release valid", 64'(out_valid[0]), 64'd0);
        check("stall release ready", 64'(in_ready[0]), 64'd1);
        tick();
        check("stall no restart ready", 64'(in_ready[0]), 64'd1);
        check("stall no restart data", out_data[0], hold);

        // Reset in the second BUSY cycle discards the partial result.
        r = {$urandom, $urandom};
        in_data[0]  = r;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort in_ready", 64'(in_ready[0]), 64'd1);
        check("abort out_valid", 64'(out_valid[0]), 64'd0);
        check("abort out_data", out_data[0], 64'd0);
        r = {$urandom, $urandom};
        run_block(0, r, ref_sub(r), "after_abort");

        for (int d = 0; d < 3; d++) run_stream(d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
